full_adder: RTL and testbench

- Registered WIDTH-bit ripple-carry adder built hierarchically.
- Each bit is one full-adder cell made of two half adders plus an OR on the two half-adder carries.
- Outputs are captured in flops one clock after a valid input.
- Used as a leaf arithmetic block and as the reference full-adder-from-half-adders building block.

---
 rtl/full_adder_pkg.sv | 4 +
 rtl/full_adder_half_adder.sv | 10 +
 rtl/full_adder.sv | 42 ++++
 tb/tb_full_adder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared configuration for the registered ripple-carry adder.
package full_adder_pkg;
  localparam int unsigned DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_half_adder.sv
// Half adder: sum and carry of two single-bit operands.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from per-bit pairs of half adders.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p, g, s, t;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha0 (.a(in1[i]), .b(in2[i]), .s(p[i]), .c(g[i]));
    half_adder u_ha1 (.a(p[i]),   .b(c[i]),   .s(s[i]), .c(t[i]));
    // OR of the two half-adder carries forms the ripple into the next bit.
    assign c[i+1] = g[i] | t[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= c[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench driving a 1-bit and an 8-bit adder instance in lockstep.
module tb_full_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       v1, cin1, co1, ov1;
  logic [0:0] a1, b1, s1;
  logic       v8, cin8, co8, ov8;
  logic [7:0] a8, b8, s8;

  logic [1:0] q1[$];
  logic [8:0] q8[$];
  logic [1:0] last1;
  logic [8:0] last8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in1(a1), .in2(b1), .cin(cin1),
    .sum(s1), .carry(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in1(a8), .in2(b8), .cin(cin8),
    .sum(s8), .carry(co8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive both instances for one cycle, then compare against the scoreboard.
  task automatic step(input logic va, input logic a, input logic b, input logic ca,
                      input logic vb, input logic [7:0] x, input logic [7:0] y,
                      input logic cb);
    v1 = va; a1 = a; b1 = b; cin1 = ca;
    v8 = vb; a8 = x; b8 = y; cin8 = cb;
    if (va) q1.push_back(2'(a) + 2'(b) + 2'(ca));
    if (vb) q8.push_back(9'(x) + 9'(y) + 9'(cb));
    @(posedge clk);
    #1;
    chk("ov1", 9'(ov1), 9'(va));
    if (va) last1 = q1.pop_front();
    chk("res1", 9'({co1, s1}), 9'(last1));
    chk("ov8", 9'(ov8), 9'(vb));
    if (vb) last8 = q8.pop_front();
    chk("res8", {co8, s8}, last8);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov1"}, 9'(ov1), 9'd0);
    chk({tag, "_res1"}, 9'({co1, s1}), 9'd0);
    chk({tag, "_ov8"}, 9'(ov8), 9'd0);
    chk({tag, "_res8"}, {co8, s8}, 9'd0);
  endtask

  initial begin
    logic ra, rb, rc, rcb;
    logic [7:0] rx, ry;
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    last1 = '0;
    last8 = '0;
    #2;
    chk_zero("reset");
    #1 rst = 1'b0;

    // WIDTH=1 exhaustive alongside WIDTH=8 boundaries
    step(1, 1, 0, 0, 1, 8'hFF, 8'h01, 0);
    step(1, 0, 0, 1, 1, 8'hFF, 8'hFF, 1);
    step(1, 0, 1, 0, 1, 8'h00, 8'h00, 1);
    step(1, 0, 1, 1, 1, 8'h55, 8'hAA, 0);
    step(1, 1, 0, 1, 1, 8'h00, 8'h00, 0);
    step(1, 1, 1, 0, 0, 8'h00, 8'h00, 0);
    step(1, 1, 1, 1, 0, 8'h00, 8'h00, 0);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0);

    // Boundary results checked against literal values as well
    step(0, 0, 0, 0, 1, 8'hFF, 8'hFF, 1);
    chk("ff_ff_1", {co8, s8}, 9'h1FF);
    step(0, 0, 0, 0, 1, 8'hFF, 8'h01, 0);
    chk("ff_01_0", {co8, s8}, 9'h100);
    step(0, 0, 0, 0, 1, 8'h55, 8'hAA, 0);
    chk("55_aa_0", {co8, s8}, 9'h0FF);

    // Hold: idle cycle with changed / unknown inputs leaves outputs untouched
    step(1, 1, 0, 0, 1, 8'h12, 8'h34, 1);
    chk("hold_pre", 9'({co1, s1}), 9'b01);
    step(0, 1, 1, 1, 0, 8'hxx, 8'hxx, 1'bx);
    chk("hold_res1", 9'({co1, s1}), 9'b01);
    chk("hold_res8", {co8, s8}, 9'h047);

    // Asynchronous reset between edges, then first valid after release
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    last1 = '0;
    last8 = '0;
    #1 rst = 1'b0;
    step(1, 1, 1, 1, 1, 8'h80, 8'h80, 1);
    chk("post_rst1", 9'({co1, s1}), 9'b11);

    // Streaming: consecutive random valids on both widths
    for (int i = 0; i < 10; i++) begin
      ra  = 1'($urandom_range(1));
      rb  = 1'($urandom_range(1));
      rc  = 1'($urandom_range(1));
      rx  = 8'($urandom_range(255));
      ry  = 8'($urandom_range(255));
      rcb = 1'($urandom_range(1));
      step(1, ra, rb, rc, 1, rx, ry, rcb);
    end
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

    chk("q1_empty", 9'(q1.size()), 9'd0);
    chk("q8_empty", 9'(q8.size()), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
